// File: rtl/boid_pixel_fetcher_pkg.sv
// Shared constants for the boid display read path.
// Holds the VGA timing constants, the pixel count of the visible area and the
// swap FSM state encoding. No logic, no latency, no backpressure.
package boid_pixel_fetcher_pkg;

  // 640x480 at 60 Hz, 25 MHz pixel clock
  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int H_TOTAL       = 800;
  localparam int V_TOTAL       = 525;
  localparam int CLK_PER_PIXEL = 2;

  localparam int PIXEL_COUNT   = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_WIDTH    = $clog2(PIXEL_COUNT);

  // Swap FSM encoding
  localparam logic [1:0] ST_SCAN        = 2'd0;
  localparam logic [1:0] ST_WAIT_WRITER = 2'd1;
  localparam logic [1:0] ST_SWAP        = 2'd2;

endpackage

// File: rtl/boid_pixel_fetcher_if.sv
// Read bus between the pixel fetcher and the 1-bit boid display RAM.
// RAM returns registered data one cycle after the address; no backpressure.
// Ports: ram_read_addr / ram_read_buf (fetcher -> RAM), ram_read_data (RAM -> fetcher).
interface boid_pixel_fetcher_if #(
  parameter int ADDR_WIDTH = 19
) ();

  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic                  ram_read_buf;
  logic                  ram_read_data;

  modport master (
    output ram_read_addr,
    output ram_read_buf,
    input  ram_read_data
  );

  modport slave (
    input  ram_read_addr,
    input  ram_read_buf,
    output ram_read_data
  );

endinterface

// File: rtl/boid_pixel_fetcher_vga_timing_counter.sv
// VGA raster position generator: pixel divider, hcount, vcount, active.
// Position outputs are registered; strobes are combinational from them. No backpressure.
// Ports: clock/reset; pix_tick_o, hcount_o, vcount_o, active_o, line_last_o, frame_wrap_o.
module vga_timing_counter #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int H_TOTAL       = 800,
  parameter int V_TOTAL       = 525,
  parameter int CLK_PER_PIXEL = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pix_tick_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       active_o,
  output logic       line_last_o,   // pix_tick on the last column of a line
  output logic       frame_wrap_o   // pix_tick on the last position of the frame
);

  localparam int DW = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_PER_PIXEL - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;

  assign pix_tick_o   = (div_q == DIV_LAST);
  assign line_last_o  = pix_tick_o && (h_q == H_LAST);
  assign frame_wrap_o = line_last_o && (v_q == V_LAST);
  assign active_o     = (h_q < H_ACT) && (v_q < V_ACT);
  assign hcount_o     = h_q;
  assign vcount_o     = v_q;

  always_comb begin
    div_d = pix_tick_o ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_tick_o) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

endmodule

// File: rtl/boid_pixel_fetcher.sv
// Raster-order reader of the double-buffered 1-bit boid display RAM.
// pixel_on/pixel_valid follow the fetch address by exactly one cycle (RAM latency).
// No backpressure: the raster free-runs; a late writer just causes a dropped swap.
// Ports: clock/reset; ram (read bus master); write_done in; write_buf, frame_end,
//        hcount, vcount, active, pixel_on, pixel_valid, dropped_frames out.
module boid_pixel_fetcher
  import boid_pixel_fetcher_pkg::*;
#(
  parameter int P_H_ACTIVE      = H_ACTIVE,
  parameter int P_V_ACTIVE      = V_ACTIVE,
  parameter int P_H_TOTAL       = H_TOTAL,
  parameter int P_V_TOTAL       = V_TOTAL,
  parameter int P_CLK_PER_PIXEL = CLK_PER_PIXEL,
  // must satisfy 2**P_ADDR_WIDTH >= P_H_ACTIVE*P_V_ACTIVE
  parameter int P_ADDR_WIDTH    = ADDR_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  boid_pixel_fetcher_if.master ram,
  input  logic                 write_done,
  output logic                 write_buf,
  output logic                 frame_end,
  output logic [9:0]           hcount,
  output logic [9:0]           vcount,
  output logic                 active,
  output logic                 pixel_on,
  output logic                 pixel_valid,
  output logic [7:0]           dropped_frames
);

  localparam logic [9:0] V_ACT_LAST = 10'(P_V_ACTIVE - 1);

  logic pix_tick;
  logic line_last;
  logic frame_wrap;

  vga_timing_counter #(
    .H_ACTIVE      (P_H_ACTIVE),
    .V_ACTIVE      (P_V_ACTIVE),
    .H_TOTAL       (P_H_TOTAL),
    .V_TOTAL       (P_V_TOTAL),
    .CLK_PER_PIXEL (P_CLK_PER_PIXEL)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .pix_tick_o   (pix_tick),
    .hcount_o     (hcount),
    .vcount_o     (vcount),
    .active_o     (active),
    .line_last_o  (line_last),
    .frame_wrap_o (frame_wrap)
  );

  // ---------------------------------------------------------------------------
  // Address generation: running linear counter instead of h + H_ACTIVE*v.
  // Zeroed on the wrap tick so it already reads 0 for the whole of pixel (0,0).
  // Past the last visible pixel it parks through blanking until the next wrap.
  // ---------------------------------------------------------------------------
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (frame_wrap) begin
      addr_d = '0;
    end else if (pix_tick && active) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read alignment: the address is stable across the whole pixel, so the RAM
  // samples it on the tick edge and its data lines up with the delayed tick.
  // ---------------------------------------------------------------------------
  logic valid_q, valid_d;

  assign valid_d     = pix_tick && active;
  assign pixel_valid = valid_q;
  assign pixel_on    = valid_q & ram.ram_read_data;

  // ---------------------------------------------------------------------------
  // Swap FSM. The buffer only toggles on the frame wrap, so it can never change
  // inside the active region.
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       buf_q, buf_d;
  logic [7:0] drop_q, drop_d;
  logic       frame_end_q, frame_end_d;
  logic       enter_vblank;

  // Tick whose next position is (0, V_ACTIVE)
  assign enter_vblank = line_last && (vcount == V_ACT_LAST);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    drop_d      = drop_q;
    frame_end_d = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (enter_vblank) begin
          state_d     = ST_WAIT_WRITER;
          frame_end_d = 1'b1;
        end
      end
      ST_WAIT_WRITER: begin
        if (frame_wrap) begin
          // A write_done coincident with the wrap still counts as on time.
          state_d = ST_SCAN;
          if (write_done) begin
            buf_d = ~buf_q;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end else if (write_done) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        if (frame_wrap) begin
          state_d = ST_SCAN;
          buf_d   = ~buf_q;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      valid_q     <= 1'b0;
      state_q     <= ST_SCAN;
      buf_q       <= 1'b0;
      drop_q      <= 8'd0;
      frame_end_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      buf_q       <= buf_d;
      drop_q      <= drop_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign ram.ram_read_addr = addr_q;
  assign ram.ram_read_buf  = buf_q;
  assign write_buf         = ~buf_q;
  assign frame_end         = frame_end_q;
  assign dropped_frames    = drop_q;

endmodule

// File: tb/tb_boid_pixel_fetcher.sv
// Directed bench for boid_pixel_fetcher on a reduced raster (8x4 visible, 12x6 total).
// One frame is 12*6*2 = 144 cycles; linear address = h + 8*v, last visible = 31.
// A behavioural two-buffer RAM returns data one cycle after the address.
module tb_boid_pixel_fetcher;
  import boid_pixel_fetcher_pkg::*;

  localparam int TH_ACT = 8;
  localparam int TV_ACT = 4;
  localparam int TH_TOT = 12;
  localparam int TV_TOT = 6;
  localparam int TCPP   = 2;
  localparam int TAW    = 5;
  localparam int FRAME  = TH_TOT * TV_TOT * TCPP;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_done = 1'b0;
  logic       write_buf, frame_end, active, pixel_on, pixel_valid;
  logic [9:0] hcount, vcount;
  logic [7:0] dropped_frames;

  int total = 0;
  int bad   = 0;

  logic mem0 [32];
  logic mem1 [32];

  boid_pixel_fetcher_if #(.ADDR_WIDTH(TAW)) rif ();

  boid_pixel_fetcher #(
    .P_H_ACTIVE      (TH_ACT),
    .P_V_ACTIVE      (TV_ACT),
    .P_H_TOTAL       (TH_TOT),
    .P_V_TOTAL       (TV_TOT),
    .P_CLK_PER_PIXEL (TCPP),
    .P_ADDR_WIDTH    (TAW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ram            (rif),
    .write_done     (write_done),
    .write_buf      (write_buf),
    .frame_end      (frame_end),
    .hcount         (hcount),
    .vcount         (vcount),
    .active         (active),
    .pixel_on       (pixel_on),
    .pixel_valid    (pixel_valid),
    .dropped_frames (dropped_frames)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    rif.ram_read_data <= rif.ram_read_buf ? mem1[rif.ram_read_addr] : mem0[rif.ram_read_addr];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    write_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_frame_end(input string tag);
    int n = 0;
    while (frame_end !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    total++;
    if (frame_end !== 1'b1) begin
      bad++;
      $display("FAIL %s_wait_frame_end: frame_end=%b after %0d cycles, required 1", tag, frame_end, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (hcount !== 10'd0) begin bad++; $display("FAIL rst_hcount: got %0d want 0", hcount); end
    total++; if (vcount !== 10'd0) begin bad++; $display("FAIL rst_vcount: got %0d want 0", vcount); end
    total++; if (rif.ram_read_addr !== 5'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", rif.ram_read_addr); end
    total++; if (rif.ram_read_buf !== 1'b0) begin bad++; $display("FAIL rst_read_buf: got %b want 0", rif.ram_read_buf); end
    total++; if (write_buf !== 1'b1) begin bad++; $display("FAIL rst_write_buf: got %b want 1", write_buf); end
    total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL rst_frame_end: got %b want 0", frame_end); end
    total++; if (pixel_on !== 1'b0) begin bad++; $display("FAIL rst_pixel_on: got %b want 0", pixel_on); end
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_pixel_valid: got %b want 0", pixel_valid); end
    total++; if (dropped_frames !== 8'd0) begin bad++; $display("FAIL rst_dropped: got %0d want 0", dropped_frames); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL rst_active: got %b want 1 at (0,0)", active); end
    total++; if (dut.state_q !== ST_SCAN) begin bad++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_SCAN); end
    step();  // divider 0 -> 1, pix_tick now high
    total++; if (hcount !== 10'd0) begin bad++; $display("FAIL tick1_hcount: got %0d want 0", hcount); end
    step();  // first pix_tick consumed
    total++; if (hcount !== 10'd1) begin bad++; $display("FAIL tick2_hcount: got %0d want 1", hcount); end
    total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL tick2_pixel_valid: got %b want 1", pixel_valid); end
    total++; if (rif.ram_read_addr !== 5'd1) begin bad++; $display("FAIL tick2_addr: got %0d want 1", rif.ram_read_addr); end
  endtask

  task automatic test_frame();
    int pulses = 0, first_at = 0, valids = 0, ons = 0, addr_err = 0;
    logic [TAW-1:0] prev_addr = '0, on_prev = '0, last_addr = '0;
    apply_reset();
    wait_frame_end("frame");
    total++; if (hcount !== 10'd0 || vcount !== 10'd4) begin
      bad++; $display("FAIL frame_end_pos: got (%0d,%0d) want (0,4)", hcount, vcount);
    end
    for (int i = 1; i <= FRAME; i++) begin
      prev_addr = rif.ram_read_addr;
      step();
      if (frame_end === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
      if (pixel_valid === 1'b1) valids++;
      if (pixel_on === 1'b1) begin ons++; on_prev = prev_addr; end
      if (active === 1'b1 && rif.ram_read_addr !== TAW'(int'(hcount) + TH_ACT * int'(vcount))) addr_err++;
      if (hcount == 10'd7 && vcount == 10'd3) last_addr = rif.ram_read_addr;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL frame_end_count: got %0d want 1", pulses); end
    total++; if (first_at != FRAME) begin bad++; $display("FAIL frame_period: got %0d want %0d", first_at, FRAME); end
    total++; if (valids != 32) begin bad++; $display("FAIL valid_count: got %0d want 32", valids); end
    total++; if (ons != 1) begin bad++; $display("FAIL pixel_on_count: got %0d want 1", ons); end
    total++; if (on_prev !== 5'd19) begin bad++; $display("FAIL pixel_on_addr: got %0d want 19", on_prev); end
    total++; if (last_addr !== 5'd31) begin bad++; $display("FAIL last_addr: got %0d want 31", last_addr); end
    total++; if (addr_err != 0) begin bad++; $display("FAIL addr_linear: %0d errors want 0", addr_err); end
    total++; if (dropped_frames !== 8'd1) begin bad++; $display("FAIL frame_dropped: got %0d want 1", dropped_frames); end
  endtask

  task automatic test_swap();
    int n = 0, ons = 0;
    logic [TAW-1:0] prev_addr = '0, on_prev = '0;
    apply_reset();
    wait_frame_end("swap");
    repeat (20) step();
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    while (rif.ram_read_buf === 1'b0 && n < 200) begin
      step();
      n++;
    end
    total++; if (rif.ram_read_buf !== 1'b1) begin bad++; $display("FAIL swap_buf: got %b want 1", rif.ram_read_buf); end
    total++; if (hcount !== 10'd0 || vcount !== 10'd0) begin
      bad++; $display("FAIL swap_pos: flipped at (%0d,%0d) want (0,0)", hcount, vcount);
    end
    total++; if (write_buf !== 1'b0) begin bad++; $display("FAIL swap_write_buf: got %b want 0", write_buf); end
    total++; if (dropped_frames !== 8'd0) begin bad++; $display("FAIL swap_dropped: got %0d want 0", dropped_frames); end
    for (int i = 0; i < FRAME - 1; i++) begin
      prev_addr = rif.ram_read_addr;
      step();
      if (pixel_on === 1'b1) begin ons++; on_prev = prev_addr; end
    end
    total++; if (ons != 1) begin bad++; $display("FAIL swap_pixel_count: got %0d want 1", ons); end
    total++; if (on_prev !== 5'd5) begin bad++; $display("FAIL swap_pixel_addr: got %0d want 5", on_prev); end
  endtask

  task automatic test_wrap_same_cycle();
    apply_reset();
    repeat (FRAME - 1) step();
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    total++; if (rif.ram_read_buf !== 1'b1) begin bad++; $display("FAIL same_cycle_buf: got %b want 1", rif.ram_read_buf); end
    total++; if (dropped_frames !== 8'd0) begin bad++; $display("FAIL same_cycle_dropped: got %0d want 0", dropped_frames); end
    total++; if (hcount !== 10'd0 || vcount !== 10'd0) begin
      bad++; $display("FAIL same_cycle_pos: got (%0d,%0d) want (0,0)", hcount, vcount);
    end
  endtask

  task automatic test_write_done_in_scan();
    apply_reset();
    repeat (10) step();
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    repeat (FRAME - 11) step();
    total++; if (rif.ram_read_buf !== 1'b0) begin bad++; $display("FAIL scan_ignore_buf: got %b want 0", rif.ram_read_buf); end
    total++; if (dropped_frames !== 8'd1) begin bad++; $display("FAIL scan_ignore_dropped: got %0d want 1", dropped_frames); end
  endtask

  task automatic test_drop_saturate();
    int buf_err = 0;
    apply_reset();
    for (int i = 0; i < FRAME * 3 - 1; i++) begin
      step();
      if (rif.ram_read_buf !== 1'b0) buf_err++;
    end
    total++; if (dropped_frames !== 8'd2) begin bad++; $display("FAIL drop_before3: got %0d want 2", dropped_frames); end
    step();
    total++; if (dropped_frames !== 8'd3) begin bad++; $display("FAIL drop_3: got %0d want 3", dropped_frames); end
    total++; if (buf_err != 0) begin bad++; $display("FAIL drop_buf_stable: %0d cycles with buf!=0 want 0", buf_err); end
    repeat (FRAME * 251) step();
    total++; if (dropped_frames !== 8'd254) begin bad++; $display("FAIL drop_254: got %0d want 254", dropped_frames); end
    repeat (FRAME) step();
    total++; if (dropped_frames !== 8'd255) begin bad++; $display("FAIL drop_255: got %0d want 255", dropped_frames); end
    repeat (FRAME * 5) step();
    total++; if (dropped_frames !== 8'd255) begin bad++; $display("FAIL drop_saturate: got %0d want 255", dropped_frames); end
    total++; if (rif.ram_read_buf !== 1'b0) begin bad++; $display("FAIL drop_buf_final: got %b want 0", rif.ram_read_buf); end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    wait_frame_end("rst_wait");
    repeat (5) step();
    reset = 1'b1;
    write_done = 1'b1;
    step();
    reset = 1'b0;
    write_done = 1'b0;
    total++; if (dut.state_q !== ST_SCAN) begin bad++; $display("FAIL rst_wait_state: got %0d want %0d", dut.state_q, ST_SCAN); end
    total++; if (rif.ram_read_buf !== 1'b0) begin bad++; $display("FAIL rst_wait_buf: got %b want 0", rif.ram_read_buf); end
    total++; if (hcount !== 10'd0 || vcount !== 10'd0) begin
      bad++; $display("FAIL rst_wait_pos: got (%0d,%0d) want (0,0)", hcount, vcount);
    end
    repeat (FRAME) step();
    total++; if (rif.ram_read_buf !== 1'b0) begin bad++; $display("FAIL rst_wait_no_swap: got %b want 0", rif.ram_read_buf); end
    total++; if (dropped_frames !== 8'd1) begin bad++; $display("FAIL rst_wait_dropped: got %0d want 1", dropped_frames); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 1'b0;
      mem1[i] = 1'b0;
    end
    mem0[19] = 1'b1;  // (3,2) in the front buffer
    mem1[5]  = 1'b1;  // (5,0) in the back buffer
    test_reset();
    test_frame();
    test_swap();
    test_wrap_same_cycle();
    test_write_done_in_scan();
    test_drop_saturate();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
